program_memory_loader: RTL and testbench

- Writer side of the instruction store: accepts a byte stream (host/UART side) and writes assembled 32-bit instructions into the writable program memory.
- Sits between the debug/boot byte source and the instruction RAM write port.
- Holds the MIPS core in reset while loading.
- Addresses it emits are byte addresses, word-aligned; the memory uses Address[..:2] as the word index.

---
 rtl/program_memory_loader_pkg.sv | 28 ++
 rtl/program_memory_loader_if.sv | 45 ++++
 rtl/program_memory_loader_word_assembler.sv | 48 ++++
 rtl/program_memory_loader.sv | 146 ++++++++++++++
 tb/tb_program_memory_loader.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/program_memory_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : program_memory_loader_pkg
//  Description : Shared constants for the program memory loader: FSM state
//                encoding, stream length field width and the default
//                instruction-store base address (also used by the fetch/PC
//                reset logic).
//  Revision    : 1.0 - initial release
// ============================================================================
package program_memory_loader_pkg;

    // Width of the big-endian word-count header at the start of the stream.
    localparam int LEN_WIDTH   = 16;
    localparam int STATE_WIDTH = 3;

    localparam logic [STATE_WIDTH-1:0] c_st_idle   = 3'd0;
    localparam logic [STATE_WIDTH-1:0] c_st_len_hi = 3'd1;
    localparam logic [STATE_WIDTH-1:0] c_st_len_lo = 3'd2;
    localparam logic [STATE_WIDTH-1:0] c_st_data   = 3'd3;
    localparam logic [STATE_WIDTH-1:0] c_st_write  = 3'd4;
    localparam logic [STATE_WIDTH-1:0] c_st_done   = 3'd5;
    localparam logic [STATE_WIDTH-1:0] c_st_error  = 3'd6;

    // Byte address of instruction word 0.
    localparam logic [31:0] DEFAULT_BASE_ADDRESS = 32'h0040_0000;

endpackage
`default_nettype wire

// File: rtl/program_memory_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : program_memory_loader_if
//  Description : Byte-stream input and program-memory write port of the
//                loader, bundled as one interface.
//  Ports       : ByteData/ByteValid  - stream byte and its qualifier
//                ByteReady           - loader accepts the byte this cycle
//                WriteEnable         - one-cycle write strobe
//                WriteAddress        - byte address of the write (aligned)
//                WriteData           - assembled 32-bit instruction
//  Modports    : master - the loader; slave - byte source + memory side
//  Revision    : 1.0 - initial release
// ============================================================================
interface program_memory_loader_if #(
    parameter int DATA_WIDTH = 32
);
    import program_memory_loader_pkg::*;

    logic [7:0]            ByteData;
    logic                  ByteValid;
    logic                  ByteReady;
    logic                  WriteEnable;
    logic [DATA_WIDTH-1:0] WriteAddress;
    logic [DATA_WIDTH-1:0] WriteData;

    modport master (
        input  ByteData,
        input  ByteValid,
        output ByteReady,
        output WriteEnable,
        output WriteAddress,
        output WriteData
    );

    modport slave (
        output ByteData,
        output ByteValid,
        input  ByteReady,
        input  WriteEnable,
        input  WriteAddress,
        input  WriteData
    );

endinterface
`default_nettype wire

// File: rtl/program_memory_loader_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : program_memory_loader_word_assembler
//  Description : Shifts incoming stream bytes MSB-first into a 32-bit word
//                and flags the cycle in which the 4th byte is taken.
//  Ports       : clk, reset      - clock, synchronous active-high reset
//                i_clear         - restart the byte count (new payload)
//                i_shift_en      - a byte transfer occurs this cycle
//                i_byte          - the byte being transferred
//                o_word          - assembly register contents
//                o_word_ready    - this transfer completes a word
//  Revision    : 1.0 - initial release
// ============================================================================
module program_memory_loader_word_assembler
    import program_memory_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  wire                   clk,
    input  wire                   reset,
    input  wire                   i_clear,
    input  wire                   i_shift_en,
    input  wire  [7:0]            i_byte,
    output logic [DATA_WIDTH-1:0] o_word,
    output logic                  o_word_ready
);

    logic [DATA_WIDTH-1:0] r_word;
    logic [1:0]            r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_word  <= '0;
            r_count <= 2'd0;
        end else if (i_clear) begin
            r_count <= 2'd0;
        end else if (i_shift_en) begin
            r_word  <= {r_word[DATA_WIDTH-9:0], i_byte};
            // Two-bit counter wraps naturally after the 4th byte.
            r_count <= r_count + 2'd1;
        end
    end

    assign o_word       = r_word;
    assign o_word_ready = i_shift_en && (r_count == 2'd3);

endmodule
`default_nettype wire

// File: rtl/program_memory_loader.sv
`default_nettype none
// ============================================================================
//  Module      : program_memory_loader
//  Description : Writer side of the instruction store. Parses a byte stream
//                {LenHi, LenLo, N*4 instruction bytes, big-endian} and writes
//                each assembled word to program memory at
//                BASE_ADDRESS + 4*index, holding the core in reset meanwhile.
//  Ports       : clk, reset   - clock, synchronous active-high reset
//                Start        - pulse to begin a load (ignored while Busy)
//                bus          - byte stream in / memory write port out
//                Busy         - load in progress
//                CpuHold      - core reset hold, same as Busy
//                Done         - last load completed
//                Error        - last load rejected (N > MEMORY_DEPTH)
//                WordsLoaded  - words written by the current/last load
//  Revision    : 1.0 - initial release
// ============================================================================
module program_memory_loader
    import program_memory_loader_pkg::*;
#(
    parameter int                    MEMORY_DEPTH = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = DEFAULT_BASE_ADDRESS
) (
    input  wire                    clk,
    input  wire                    reset,
    input  wire                    Start,
    program_memory_loader_if.master bus,
    output logic                   Busy,
    output logic                   CpuHold,
    output logic                   Done,
    output logic                   Error,
    output logic [LEN_WIDTH-1:0]   WordsLoaded
);

    localparam logic [LEN_WIDTH:0]   c_depth = (LEN_WIDTH+1)'(MEMORY_DEPTH);
    localparam logic [LEN_WIDTH-1:0] c_one   = LEN_WIDTH'(1);
    localparam int                   c_pad   = DATA_WIDTH - LEN_WIDTH - 2;

    logic [STATE_WIDTH-1:0] r_state;
    logic [LEN_WIDTH-1:0]   r_len;
    logic [LEN_WIDTH-1:0]   r_index;
    logic [LEN_WIDTH-1:0]   r_words_loaded;
    logic [DATA_WIDTH-1:0]  r_write_address;

    logic                   w_byte_ready;
    logic                   w_xfer;
    logic                   w_asm_clear;
    logic                   w_asm_shift;
    logic                   w_word_ready;
    logic [DATA_WIDTH-1:0]  w_word;
    logic [LEN_WIDTH-1:0]   w_len_full;
    logic [LEN_WIDTH-1:0]   w_index_next;
    logic [DATA_WIDTH-1:0]  w_addr_of_index;

    assign w_byte_ready = (r_state == c_st_len_hi) ||
                          (r_state == c_st_len_lo) ||
                          (r_state == c_st_data);
    assign w_xfer       = bus.ByteValid && w_byte_ready;
    assign w_asm_clear  = (r_state == c_st_len_lo) && w_xfer;
    assign w_asm_shift  = (r_state == c_st_data) && w_xfer;

    // Full count as it will be once the low byte is latched this cycle.
    assign w_len_full      = {r_len[LEN_WIDTH-1:8], bus.ByteData};
    assign w_index_next    = r_index + c_one;
    assign w_addr_of_index = BASE_ADDRESS + {{c_pad{1'b0}}, r_index, 2'b00};

    program_memory_loader_word_assembler #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_word_assembler (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (w_asm_clear),
        .i_shift_en   (w_asm_shift),
        .i_byte       (bus.ByteData),
        .o_word       (w_word),
        .o_word_ready (w_word_ready)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= c_st_idle;
            r_len           <= '0;
            r_index         <= '0;
            r_words_loaded  <= '0;
            r_write_address <= BASE_ADDRESS;
        end else begin
            case (r_state)
                c_st_idle, c_st_done, c_st_error: begin
                    if (Start) begin
                        r_state        <= c_st_len_hi;
                        r_words_loaded <= '0;
                    end
                end
                c_st_len_hi: begin
                    if (w_xfer) begin
                        r_len[LEN_WIDTH-1:8] <= bus.ByteData;
                        r_state              <= c_st_len_lo;
                    end
                end
                c_st_len_lo: begin
                    if (w_xfer) begin
                        r_len <= w_len_full;
                        if (w_len_full == '0) begin
                            r_state <= c_st_done;
                        end else if ({1'b0, w_len_full} > c_depth) begin
                            r_state <= c_st_error;
                        end else begin
                            r_state <= c_st_data;
                            r_index <= '0;
                        end
                    end
                end
                c_st_data: begin
                    if (w_word_ready) begin
                        r_state         <= c_st_write;
                        // Address is captured here so it is stable for the
                        // whole strobe cycle.
                        r_write_address <= w_addr_of_index;
                    end
                end
                c_st_write: begin
                    r_index        <= w_index_next;
                    r_words_loaded <= r_words_loaded + c_one;
                    r_state        <= (w_index_next == r_len) ? c_st_done : c_st_data;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // All status outputs are pure decodes of the state register.
    assign bus.ByteReady    = w_byte_ready;
    assign bus.WriteEnable  = (r_state == c_st_write);
    assign bus.WriteAddress = r_write_address;
    assign bus.WriteData    = w_word;
    assign Busy             = w_byte_ready || (r_state == c_st_write);
    assign CpuHold          = Busy;
    assign Done             = (r_state == c_st_done);
    assign Error            = (r_state == c_st_error);
    assign WordsLoaded      = r_words_loaded;

endmodule
`default_nettype wire

// File: tb/tb_program_memory_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_program_memory_loader
//  Description : Directed self-checking bench for program_memory_loader.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_program_memory_loader;
    import program_memory_loader_pkg::*;

    localparam logic [31:0] c_base = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic        Busy;
    logic        CpuHold;
    logic        Done;
    logic        Error;
    logic [15:0] WordsLoaded;

    int total = 0;
    int bad   = 0;

    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];

    always #5 clk = ~clk;

    program_memory_loader_if #(.DATA_WIDTH(32)) pif ();

    program_memory_loader #(
        .MEMORY_DEPTH (32),
        .DATA_WIDTH   (32),
        .BASE_ADDRESS (c_base)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .Start       (Start),
        .bus         (pif),
        .Busy        (Busy),
        .CpuHold     (CpuHold),
        .Done        (Done),
        .Error       (Error),
        .WordsLoaded (WordsLoaded)
    );

    // Capture every write strobe mid-cycle.
    always @(negedge clk) begin
        if (pif.WriteEnable) begin
            wa_q.push_back(pif.WriteAddress);
            wd_q.push_back(pif.WriteData);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        pif.ByteData  = b;
        pif.ByteValid = 1'b1;
        while (!pif.ByteReady && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!pif.ByteReady) begin
            check_eq("byte_accept_timeout", 32'(pif.ByteReady), 32'd1);
            pif.ByteValid = 1'b0;
        end else begin
            @(negedge clk);
            pif.ByteValid = 1'b0;
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        reset         = 1'b1;
        Start         = 1'b0;
        pif.ByteData  = 8'h00;
        pif.ByteValid = 1'b0;
        repeat (3) @(negedge clk);

        // ---- reset state
        check_eq("rst_busy",   32'(Busy), 0);
        check_eq("rst_hold",   32'(CpuHold), 0);
        check_eq("rst_done",   32'(Done), 0);
        check_eq("rst_error",  32'(Error), 0);
        check_eq("rst_ready",  32'(pif.ByteReady), 0);
        check_eq("rst_we",     32'(pif.WriteEnable), 0);
        check_eq("rst_waddr",  pif.WriteAddress, c_base);
        check_eq("rst_wdata",  pif.WriteData, 0);
        check_eq("rst_words",  32'(WordsLoaded), 0);
        reset = 1'b0;
        @(negedge clk);

        // ---- two-word load
        wa_q.delete(); wd_q.delete();
        pulse_start();
        check_eq("t1_busy_after_start", 32'(Busy), 1);
        send_byte(8'h00); send_byte(8'h02);
        send_word(32'h2008_0005);
        send_word(32'h2009_000A);
        check_eq("t1_we_latency", 32'(pif.WriteEnable), 1);
        check_eq("t1_busy_in_write", 32'(Busy), 1);
        @(negedge clk);
        check_eq("t1_done",  32'(Done), 1);
        check_eq("t1_busy",  32'(Busy), 0);
        check_eq("t1_hold",  32'(CpuHold), 0);
        check_eq("t1_words", 32'(WordsLoaded), 2);
        check_eq("t1_ready", 32'(pif.ByteReady), 0);
        check_eq("t1_nwr",   wa_q.size(), 2);
        if (wa_q.size() == 2) begin
            check_eq("t1_a0", wa_q[0], 32'h0040_0000);
            check_eq("t1_d0", wd_q[0], 32'h2008_0005);
            check_eq("t1_a1", wa_q[1], 32'h0040_0004);
            check_eq("t1_d1", wd_q[1], 32'h2009_000A);
        end

        // ---- zero-length load
        wa_q.delete(); wd_q.delete();
        pulse_start();
        check_eq("t2_words_cleared", 32'(WordsLoaded), 0);
        check_eq("t2_done_cleared",  32'(Done), 0);
        send_byte(8'h00); send_byte(8'h00);
        check_eq("t2_done",  32'(Done), 1);
        check_eq("t2_words", 32'(WordsLoaded), 0);
        repeat (2) @(negedge clk);
        check_eq("t2_nwr",   wa_q.size(), 0);

        // ---- oversize length, then recovery
        pulse_start();
        send_byte(8'h00); send_byte(8'h21);
        check_eq("t3_error", 32'(Error), 1);
        check_eq("t3_ready", 32'(pif.ByteReady), 0);
        check_eq("t3_busy",  32'(Busy), 0);
        repeat (2) @(negedge clk);
        check_eq("t3_error_hold", 32'(Error), 1);
        check_eq("t3_nwr", wa_q.size(), 0);
        pulse_start();
        check_eq("t3_error_cleared", 32'(Error), 0);
        send_byte(8'h00); send_byte(8'h01);
        send_word(32'h1122_3344);
        @(negedge clk);
        check_eq("t3b_done",  32'(Done), 1);
        check_eq("t3b_error", 32'(Error), 0);
        check_eq("t3b_nwr",   wa_q.size(), 1);
        if (wa_q.size() == 1) begin
            check_eq("t3b_a0", wa_q[0], 32'h0040_0000);
            check_eq("t3b_d0", wd_q[0], 32'h1122_3344);
        end

        // ---- gapped ByteValid with a Start pulse mid-stream
        wa_q.delete(); wd_q.delete();
        pulse_start();
        @(negedge clk); send_byte(8'h00);
        @(negedge clk); send_byte(8'h01);
        @(negedge clk); send_byte(8'h11);
        @(negedge clk); send_byte(8'h22);
        pulse_start();
        check_eq("t4_still_busy",  32'(Busy), 1);
        check_eq("t4_still_ready", 32'(pif.ByteReady), 1);
        @(negedge clk); send_byte(8'h33);
        @(negedge clk); send_byte(8'h44);
        @(negedge clk);
        check_eq("t4_done", 32'(Done), 1);
        check_eq("t4_nwr",  wa_q.size(), 1);
        if (wa_q.size() == 1) begin
            check_eq("t4_a0", wa_q[0], 32'h0040_0000);
            check_eq("t4_d0", wd_q[0], 32'h1122_3344);
        end

        // ---- reset in the middle of a 3-word load
        wa_q.delete(); wd_q.delete();
        pulse_start();
        send_byte(8'h00); send_byte(8'h03);
        send_word(32'hAABB_CCDD);
        send_byte(8'h01); send_byte(8'h02);
        reset = 1'b1;
        @(negedge clk);
        check_eq("t5_busy",  32'(Busy), 0);
        check_eq("t5_hold",  32'(CpuHold), 0);
        check_eq("t5_done",  32'(Done), 0);
        check_eq("t5_error", 32'(Error), 0);
        check_eq("t5_ready", 32'(pif.ByteReady), 0);
        check_eq("t5_we",    32'(pif.WriteEnable), 0);
        check_eq("t5_words", 32'(WordsLoaded), 0);
        check_eq("t5_waddr", pif.WriteAddress, c_base);
        check_eq("t5_wdata", pif.WriteData, 0);
        check_eq("t5_nwr",   wa_q.size(), 1);
        if (wa_q.size() == 1)
            check_eq("t5_d0", wd_q[0], 32'hAABB_CCDD);
        reset = 1'b0;
        @(negedge clk);
        wa_q.delete(); wd_q.delete();
        pulse_start();
        send_byte(8'h00); send_byte(8'h01);
        send_word(32'hCAFE_F00D);
        @(negedge clk);
        check_eq("t5b_done", 32'(Done), 1);
        check_eq("t5b_nwr",  wa_q.size(), 1);
        if (wa_q.size() == 1) begin
            check_eq("t5b_a0", wa_q[0], 32'h0040_0000);
            check_eq("t5b_d0", wd_q[0], 32'hCAFE_F00D);
        end

        // ---- full-depth load: word i = bytes {i, i+1, i+2, i+3}
        wa_q.delete(); wd_q.delete();
        pulse_start();
        send_byte(8'h00); send_byte(8'h20);
        for (int i = 0; i < 32; i++) begin
            w = {8'(i), 8'(i + 1), 8'(i + 2), 8'(i + 3)};
            send_word(w);
        end
        @(negedge clk);
        check_eq("t6_done",  32'(Done), 1);
        check_eq("t6_words", 32'(WordsLoaded), 32);
        repeat (5) @(negedge clk);
        check_eq("t6_nwr",   wa_q.size(), 32);
        if (wa_q.size() == 32) begin
            for (int i = 0; i < 32; i++) begin
                w = {8'(i), 8'(i + 1), 8'(i + 2), 8'(i + 3)};
                check_eq($sformatf("t6_a%0d", i), wa_q[i], c_base + 32'(4 * i));
                check_eq($sformatf("t6_d%0d", i), wd_q[i], w);
            end
            check_eq("t6_last_addr", wa_q[31], 32'h0040_007C);
            check_eq("t6_last_data", wd_q[31], 32'h1F20_2122);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
